// File: rtl/serial_adder_if.sv
// serial_adder_if: start/operand/result bundle for serial_adder.
// The ovf signal exists only when SERIAL_ADDER_OVF_EN is defined.
//
// Handshake: the requester raises start with a/b/cin valid. The adder
// accepts on any rising edge where start=1 and it is idle or in its
// done cycle. busy is high for the WIDTH cycles of the add, and
// start is ignored during that time. done pulses for one cycle with
// sum/cout (and ovf) valid. Those results hold until the next completion.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif
    logic [1:0]       state_dbg;

`ifdef SERIAL_ADDER_OVF_EN
    modport master (output start, a, b, cin,
                    input  busy, done, sum, cout, ovf, state_dbg);
    modport slave  (input  start, a, b, cin,
                    output busy, done, sum, cout, ovf, state_dbg);
`else
    modport master (output start, a, b, cin,
                    input  busy, done, sum, cout, state_dbg);
    modport slave  (input  start, a, b, cin,
                    output busy, done, sum, cout, state_dbg);
`endif
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder with a registered carry.
// It adds one bit per clock, so a WIDTH-bit add takes WIDTH RUN cycles.
// It is followed by a one-cycle DONE.
// Optional macro SERIAL_ADDER_OVF_EN adds a registered signed-overflow flag.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input logic          clk,
    input logic          rst,
    serial_adder_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             busy_c;
    logic             done_c;
    logic             accept;
    logic             last;
    logic             fa_s;
    logic             fa_c;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q;
`endif

    // One-bit full-adder cell applied to the current LSBs and the running carry.
    assign fa_s     = a_sr[0] ^ b_sr[0] ^ carry;
    assign fa_c     = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
    assign res_next = {fa_s, res_sr[WIDTH-1:1]};

    assign accept = ((state == IDLE) || (state == DONE)) && bus.start;
    assign last   = (state == RUN) && (cnt == CW'(WIDTH - 1));

    // State register; reset returns to IDLE and aborts any add in flight.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state and status outputs.
    always_comb begin
        state_next = state;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        case (state)
            IDLE: if (bus.start) state_next = RUN;
            RUN: begin
                busy_c = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                done_c     = 1'b1;
                state_next = bus.start ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand shift, carry, bit counter and result publication.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q  <= 1'b0;
`endif
        end else if (accept) begin
            a_sr   <= bus.a;
            b_sr   <= bus.b;
            res_sr <= '0;
            carry  <= bus.cin;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_next;
            carry  <= fa_c;
            // Hold the counter on the last bit so it never wraps mid-operation.
            if (!last) cnt <= cnt + CW'(1);
            // Publish only complete results; partial sums stay internal.
            if (last) begin
                sum_q  <= res_next;
                cout_q <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
                // The carry entering the MSB is the running carry on the last bit.
                ovf_q  <= carry ^ fa_c;
`endif
            end
        end
    end

    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.state_dbg = state;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks for serial_adder at WIDTH=8.
// It also runs an exhaustive sweep against a WIDTH=4 instance.
// ovf checks are compiled in when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;
    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    serial_adder_if #(.WIDTH(8)) bus8 ();
    serial_adder_if #(.WIDTH(4)) bus4 ();

    serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] va    [5] = '{8'h00, 8'hFF, 8'hA5, 8'h7F, 8'h80};
    logic [7:0] vb    [5] = '{8'h00, 8'h01, 8'h5A, 8'h01, 8'h80};
    logic       vc    [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] vsum  [5] = '{8'h00, 8'h00, 8'h00, 8'h80, 8'h00};
    logic       vcout [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic       vovf  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    task automatic test_reset();
        rst = 1'b1;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (bus8.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b want=0", bus8.busy); end
        tests_run++;
        if (bus8.done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got=%b want=0", bus8.done); end
        tests_run++;
        if (bus8.sum !== 8'h00) begin tests_failed++; $display("FAIL reset_sum got=%h want=00", bus8.sum); end
        tests_run++;
        if (bus8.cout !== 1'b0) begin tests_failed++; $display("FAIL reset_cout got=%b want=0", bus8.cout); end
        tests_run++;
        if (bus8.state_dbg !== 2'd0) begin tests_failed++; $display("FAIL reset_state got=%0d want=0", bus8.state_dbg); end
`ifdef SERIAL_ADDER_OVF_EN
        tests_run++;
        if (bus8.ovf !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf got=%b want=0", bus8.ovf); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_vectors();
        for (int i = 0; i < 5; i++) begin
            logic run_ok;
            @(negedge clk);
            bus8.start = 1'b1; bus8.a = va[i]; bus8.b = vb[i]; bus8.cin = vc[i];
            @(posedge clk);
            run_ok = 1'b1;
            for (int k = 1; k <= 8; k++) begin
                @(negedge clk);
                bus8.start = 1'b0;
                if (bus8.busy !== 1'b1 || bus8.done !== 1'b0) run_ok = 1'b0;
            end
            tests_run++;
            if (run_ok !== 1'b1) begin tests_failed++; $display("FAIL vec%0d_busy_window got=%b want=1", i, run_ok); end
            @(negedge clk);
            tests_run++;
            if (bus8.done !== 1'b1 || bus8.busy !== 1'b0) begin
                tests_failed++; $display("FAIL vec%0d_done_timing got done=%b busy=%b want done=1 busy=0", i, bus8.done, bus8.busy);
            end
            tests_run++;
            if ({bus8.cout, bus8.sum} !== {vcout[i], vsum[i]}) begin
                tests_failed++; $display("FAIL vec%0d_result got=%b/%h want=%b/%h", i, bus8.cout, bus8.sum, vcout[i], vsum[i]);
            end
`ifdef SERIAL_ADDER_OVF_EN
            tests_run++;
            if (bus8.ovf !== vovf[i]) begin tests_failed++; $display("FAIL vec%0d_ovf got=%b want=%b", i, bus8.ovf, vovf[i]); end
`endif
            @(negedge clk);
            tests_run++;
            if (bus8.done !== 1'b0 || bus8.state_dbg !== 2'd0 || bus8.sum !== vsum[i]) begin
                tests_failed++; $display("FAIL vec%0d_after_done got done=%b state=%0d sum=%h want 0/0/%h", i, bus8.done, bus8.state_dbg, bus8.sum, vsum[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic run_ok;
        // First add 0x12+0x34; start re-pulsed mid-run with other operands.
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'h12; bus8.b = 8'h34; bus8.cin = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            bus8.start = (k == 3);
            if (k == 3) begin bus8.a = 8'h11; bus8.b = 8'h22; end
        end
        @(negedge clk);
        tests_run++;
        if (bus8.done !== 1'b1 || bus8.sum !== 8'h46 || bus8.cout !== 1'b0) begin
            tests_failed++; $display("FAIL ignore_start got done=%b sum=%h cout=%b want 1/46/0", bus8.done, bus8.sum, bus8.cout);
        end
        // Hold start through DONE: the next add begins immediately.
        bus8.start = 1'b1; bus8.a = 8'h03; bus8.b = 8'h04; bus8.cin = 1'b0;
        @(posedge clk);
        run_ok = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            bus8.start = 1'b0;
            if (bus8.busy !== 1'b1 || bus8.sum !== 8'h46) run_ok = 1'b0;
        end
        tests_run++;
        if (run_ok !== 1'b1) begin tests_failed++; $display("FAIL b2b_run_hold got=%b want=1", run_ok); end
        @(negedge clk);
        tests_run++;
        if (bus8.done !== 1'b1 || bus8.sum !== 8'h07 || bus8.cout !== 1'b0) begin
            tests_failed++; $display("FAIL b2b_result got done=%b sum=%h cout=%b want 1/07/0", bus8.done, bus8.sum, bus8.cout);
        end
    endtask

    task automatic test_reset_mid_run();
        logic saw_done;
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'h55; bus8.b = 8'h33; bus8.cin = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            bus8.start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.sum !== 8'h00 || bus8.cout !== 1'b0 || bus8.state_dbg !== 2'd0) begin
            tests_failed++; $display("FAIL midrun_reset got busy=%b done=%b sum=%h cout=%b state=%0d want all 0",
                                     bus8.busy, bus8.done, bus8.sum, bus8.cout, bus8.state_dbg);
        end
        saw_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus8.done !== 1'b0) saw_done = 1'b1;
        end
        tests_run++;
        if (saw_done !== 1'b0) begin tests_failed++; $display("FAIL midrun_no_done got=%b want=0", saw_done); end
        // Fresh add after the abort: 0x55+0x33 = 0x88, signed overflow.
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'h55; bus8.b = 8'h33; bus8.cin = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            bus8.start = 1'b0;
        end
        @(negedge clk);
        tests_run++;
        if (bus8.done !== 1'b1 || bus8.sum !== 8'h88 || bus8.cout !== 1'b0) begin
            tests_failed++; $display("FAIL after_reset_add got done=%b sum=%h cout=%b want 1/88/0", bus8.done, bus8.sum, bus8.cout);
        end
`ifdef SERIAL_ADDER_OVF_EN
        tests_run++;
        if (bus8.ovf !== 1'b1) begin tests_failed++; $display("FAIL after_reset_ovf got=%b want=1", bus8.ovf); end
`endif
    endtask

    task automatic test_sweep_w4();
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    logic       got;
                    logic [4:0] expv;
                    expv = 5'(ia) + 5'(ib) + 5'(ic);
                    @(negedge clk);
                    bus4.start = 1'b1; bus4.a = 4'(ia); bus4.b = 4'(ib); bus4.cin = ic[0];
                    @(posedge clk);
                    @(negedge clk);
                    bus4.start = 1'b0;
                    got = 1'b0;
                    for (int k = 0; k < 8 && !got; k++) begin
                        if (bus4.done === 1'b1) got = 1'b1;
                        else @(negedge clk);
                    end
                    tests_run++;
                    if (got !== 1'b1 || {bus4.cout, bus4.sum} !== expv) begin
                        tests_failed++;
                        $display("FAIL sweep4 a=%h b=%h cin=%0d got done=%b val=%h want done=1 val=%h",
                                 ia[3:0], ib[3:0], ic, got, {bus4.cout, bus4.sum}, expv);
                    end
                end
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_vectors();
        test_back_to_back();
        test_reset_mid_run();
        test_sweep_w4();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
